div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the E stage for MIPS DIV/DIVU.
- It is the producer end of the hazard unit's divide-stall interface.
- It drives div_running, which the hazard unit turns into stallF/D/E/M/W.
- It delivers quotient/remainder with a one-cycle result_ready pulse for the HI/LO write path.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified).
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  E-stage divide op present; level, held while the pipeline stalls.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU.
- a  input  32  dividend (rs value after E forwarding).
- b  input  32  divisor (rt value after E forwarding).
- annul  input  1  cancel: exception/flush of E stage.
- div_running  output  1  to hazard unit; high = stall the pipeline.
- result_ready  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  32  to LO.
- remainder  output  32  to HI.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- States:
  - IDLE, BUSY, DONE; 2-bit encoding.
  - Reset value IDLE.
  - Counter resets to 0; quotient and remainder reset to 0.
  - result_ready resets to 0.
- div_running is combinational: ~annul & ((IDLE & start) | BUSY). It is 0 in DONE and 0 during reset.
- IDLE:
  - If start & ~annul, latch signed_div, sign_q = a[31]^b[31] and sign_r = a[31] (signed only; else 0).
  - Latch |a| and |b|: two's-complement negate when signed and MSB set; unsigned otherwise.
  - Clear the partial remainder and counter.
  - If b == 0, go to DONE, else go to BUSY.
- BUSY:
  - One iteration per cycle: shift {rem, dividend} left by 1, then trial-subtract |b| from the 33-bit rem.
  - If the trial result is non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments each cycle; after 32 iterations (counter == 31 this cycle) go to DONE.
- DONE:
  - result_ready = 1 for exactly this cycle.
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r.
  - quotient/remainder are registered on the BUSY→DONE (or IDLE→DONE) edge and are stable in DONE.
  - Next state is always IDLE; start is ignored in DONE (it is the same instruction leaving E).
- Latency, b != 0:
  - div_running high for 33 cycles (1 IDLE + 32 BUSY).
  - result_ready is asserted in cycle 34 counting the start cycle as 1.
- Latency, b == 0: div_running high 1 cycle; result_ready in cycle 2.
- Divide by zero result (architecturally undefined): quotient = 32'hFFFFFFFF, remainder = a unmodified, for both signed and unsigned.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Magnitude arithmetic is 32-bit unsigned, so the negation wraps.
- quotient/remainder hold their last value outside DONE. Consumers qualify with result_ready only.
- annul:
  - Any state goes to IDLE next cycle; div_running forced to 0 the same cycle.
  - No result_ready pulse for the cancelled op; quotient/remainder not updated.
  - annul in DONE suppresses result_ready.
- rst mid-operation: state IDLE next cycle, all outputs at reset values, no result_ready.
- Back-to-back divides: start high in the cycle after DONE (new instruction in E) begins a fresh operation from IDLE.

Test Plan:
- DIVU a=100, b=7, start held → div_running = 1 for 33 cycles; result_ready pulse in cycle 34 with quotient=14, remainder=2; then IDLE, div_running=0.
- DIV a=0xFFFFFFF9 (-7), b=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- DIV a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU a=0xFFFFFFFF, b=1 → quotient=0xFFFFFFFF, remainder=0.
- Divide by zero, DIVU a=0x1234, b=0 → div_running high 1 cycle; result_ready in cycle 2 with quotient=0xFFFFFFFF, remainder=0x1234.
- annul at BUSY iteration 10 → div_running 0 that cycle, no result_ready ever. Then start a=9, b=3 → quotient=3, remainder=0 after the normal 33+1 cycles.
- rst at BUSY iteration 20 → next cycle IDLE, result_ready=0, quotient/remainder=0. start held through DONE → no second run. start re-asserted after DONE → second op completes correctly.

Source files
------------

// File: rtl/div_unit_if.sv
// Divider request/response bundle: E-stage operands and controls in,
// stall request and HI/LO result out.
`timescale 1ns/1ps
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             div_running;
    logic             result_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, a, b, annul,
        input  div_running, result_ready, quotient, remainder
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output div_running, result_ready, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; stalls the
// pipeline through div_running and pulses result_ready for the HI/LO write.
`timescale 1ns/1ps
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave dif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remd_q;
    logic             rdy_q;

    logic [WIDTH:0]   rem_sh_d;
    logic [WIDTH-1:0] diff_d;
    logic             qbit_d;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] dvd_d;
    logic             a_neg_d;
    logic             b_neg_d;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // One restoring step: shift {rem, dividend} left, trial-subtract |b|.
    // The shifted remainder is below 2*|b|, so a set carry bit means it fits.
    always_comb begin
        rem_sh_d = {prem_q, dvd_q[WIDTH-1]};
        qbit_d   = rem_sh_d[WIDTH] | (rem_sh_d[WIDTH-1:0] >= dvs_q);
        diff_d   = rem_sh_d[WIDTH-1:0] - dvs_q;
        prem_d   = qbit_d ? diff_d : rem_sh_d[WIDTH-1:0];
        dvd_d    = {dvd_q[WIDTH-2:0], qbit_d};
        a_neg_d  = dif.signed_div & dif.a[WIDTH-1];
        b_neg_d  = dif.signed_div & dif.b[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            rdy_q   <= 1'b0;
        end else if (dif.annul) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dif.start) begin
                        quot_neg_q <= a_neg_d ^ b_neg_d;
                        rem_neg_q  <= a_neg_d;
                        dvd_q      <= neg_if(a_neg_d, dif.a);
                        dvs_q      <= neg_if(b_neg_d, dif.b);
                        prem_q     <= '0;
                        cnt_q      <= '0;
                        // Divide by zero: all-ones quotient, raw dividend as remainder.
                        if (dif.b == '0) begin
                            state_q <= DONE;
                            rdy_q   <= 1'b1;
                            quot_q  <= '1;
                            remd_q  <= dif.a;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_q  <= dvd_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= DONE;
                        rdy_q   <= 1'b1;
                        quot_q  <= neg_if(quot_neg_q, dvd_d);
                        remd_q  <= neg_if(rem_neg_q, prem_d);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dif.div_running  = ~rst & ~dif.annul &
                              (((state_q == IDLE) & dif.start) | (state_q == BUSY));
    assign dif.result_ready = ~rst & ~dif.annul & rdy_q;
    assign dif.quotient     = quot_q;
    assign dif.remainder    = remd_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed MIPS cases, randomized ops against an
// arithmetic reference, annul, mid-op reset and back-to-back issue.
`timescale 1ns/1ps
module tb_div_unit;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    div_unit_if #(.WIDTH(32)) ifc ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .dif (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                                    output logic [31:0] q, output logic [31:0] r);
        int signed sa;
        int signed sb;
        sa = av;
        sb = bv;
        if (bv == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = av;
        end else if (sg && av == 32'h80000000 && bv == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    // Holds start with the given operands until result_ready (bounded), one
    // cycle per iteration; start is left high through the ready cycle.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                         output int run_cnt, output int rdy_cyc,
                         output logic [31:0] qo, output logic [31:0] ro, output logic run_in_done);
        bit seen;
        seen        = 1'b0;
        run_cnt     = 0;
        rdy_cyc     = 0;
        qo          = 32'hDEADBEEF;
        ro          = 32'hDEADBEEF;
        run_in_done = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            ifc.start      = 1'b1;
            ifc.a          = av;
            ifc.b          = bv;
            ifc.signed_div = sg;
            ifc.annul      = 1'b0;
            #1;
            if (ifc.div_running) run_cnt++;
            if (ifc.result_ready) begin
                seen        = 1'b1;
                rdy_cyc     = c;
                qo          = ifc.quotient;
                ro          = ifc.remainder;
                run_in_done = ifc.div_running;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        ifc.start = 1'b1;
        ifc.b     = 32'd5;
        #1;
        total_cnt++;
        if (ifc.div_running !== 1'b0) $display("FAIL reset_running: got %b expected 0", ifc.div_running);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (ifc.result_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ifc.result_ready);
        else pass_cnt++;
        total_cnt++;
        if (ifc.quotient !== 32'd0 || ifc.remainder !== 32'd0)
            $display("FAIL reset_result: got q=%h r=%h expected 0/0", ifc.quotient, ifc.remainder);
        else pass_cnt++;
        @(negedge clk);
        rst       = 1'b0;
        ifc.start = 1'b0;
        #1;
        total_cnt++;
        if (ifc.div_running !== 1'b0) $display("FAIL idle_running: got %b expected 0", ifc.div_running);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] da [7];
        logic [31:0] db [7];
        logic        ds [7];
        logic [31:0] q, r, eq, er;
        logic        rid;
        int          rc, rdy;
        da[0] = 32'd100;       db[0] = 32'd7;          ds[0] = 1'b0;
        da[1] = 32'hFFFFFFF9;  db[1] = 32'd2;          ds[1] = 1'b1;
        da[2] = 32'd7;         db[2] = 32'hFFFFFFFE;   ds[2] = 1'b1;
        da[3] = 32'h80000000;  db[3] = 32'hFFFFFFFF;   ds[3] = 1'b1;
        da[4] = 32'hFFFFFFFF;  db[4] = 32'd1;          ds[4] = 1'b0;
        da[5] = 32'h00001234;  db[5] = 32'd0;          ds[5] = 1'b0;
        da[6] = 32'hFFFFFFF0;  db[6] = 32'd0;          ds[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ref_div(da[i], db[i], ds[i], eq, er);
            do_op(da[i], db[i], ds[i], rc, rdy, q, r, rid);
            total_cnt++;
            if (q !== eq || r !== er)
                $display("FAIL dir%0d_result: got q=%h r=%h expected q=%h r=%h", i, q, r, eq, er);
            else pass_cnt++;
            total_cnt++;
            if (rdy !== ((db[i] == 0) ? 2 : 34))
                $display("FAIL dir%0d_latency: got ready cycle %0d expected %0d", i, rdy, (db[i] == 0) ? 2 : 34);
            else pass_cnt++;
            total_cnt++;
            if (rc !== ((db[i] == 0) ? 1 : 33) || rid !== 1'b0)
                $display("FAIL dir%0d_running: got %0d cycles (done=%b) expected %0d (done=0)",
                         i, rc, rid, (db[i] == 0) ? 1 : 33);
            else pass_cnt++;
            @(negedge clk);
            ifc.start = 1'b0;
            #1;
            total_cnt++;
            if (ifc.div_running !== 1'b0 || ifc.result_ready !== 1'b0)
                $display("FAIL dir%0d_after: got running=%b ready=%b expected 0/0",
                         i, ifc.div_running, ifc.result_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, q, r, eq, er;
        logic        sg, rid;
        int          rc, rdy, sel;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            av  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case (sel)
                0:       bv = 32'd0;
                1:       bv = $urandom_range(1, 15);
                2:       bv = 32'hFFFFFFFF;
                3:       bv = $urandom >> $urandom_range(0, 31);
                default: bv = $urandom;
            endcase
            sg = $urandom_range(0, 1);
            ref_div(av, bv, sg, eq, er);
            do_op(av, bv, sg, rc, rdy, q, r, rid);
            total_cnt++;
            if (q !== eq || r !== er || rdy !== ((bv == 0) ? 2 : 34))
                $display("FAIL rand%0d: a=%h b=%h s=%b got q=%h r=%h cyc=%0d expected q=%h r=%h cyc=%0d",
                         i, av, bv, sg, q, r, rdy, eq, er, (bv == 0) ? 2 : 34);
            else pass_cnt++;
            @(negedge clk);
            ifc.start = 1'b0;
        end
    endtask

    task automatic test_annul();
        logic [31:0] q0, r0, q, r;
        logic        rid;
        int          rc, rdy, bad_rdy, bad_run;
        q0 = ifc.quotient;
        r0 = ifc.remainder;
        // Cycle 1 is IDLE, BUSY iteration k is cycle k+2.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ifc.start      = 1'b1;
            ifc.a          = 32'd1000;
            ifc.b          = 32'd3;
            ifc.signed_div = 1'b0;
            ifc.annul      = (c == 12);
            #1;
            if (c == 11) begin
                total_cnt++;
                if (ifc.div_running !== 1'b1) $display("FAIL annul_pre_running: got %b expected 1", ifc.div_running);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ifc.div_running !== 1'b0) $display("FAIL annul_running: got %b expected 0", ifc.div_running);
        else pass_cnt++;
        bad_rdy = 0;
        bad_run = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            ifc.annul = 1'b0;
            #1;
            if (ifc.result_ready) bad_rdy++;
            if (ifc.div_running) bad_run++;
        end
        total_cnt++;
        if (bad_rdy !== 0 || bad_run !== 0)
            $display("FAIL annul_no_result: got %0d ready / %0d running cycles expected 0/0", bad_rdy, bad_run);
        else pass_cnt++;
        total_cnt++;
        if (ifc.quotient !== q0 || ifc.remainder !== r0)
            $display("FAIL annul_hold: got q=%h r=%h expected q=%h r=%h", ifc.quotient, ifc.remainder, q0, r0);
        else pass_cnt++;
        do_op(32'd9, 32'd3, 1'b0, rc, rdy, q, r, rid);
        total_cnt++;
        if (q !== 32'd3 || r !== 32'd0 || rdy !== 34)
            $display("FAIL annul_next_op: got q=%h r=%h cyc=%0d expected q=3 r=0 cyc=34", q, r, rdy);
        else pass_cnt++;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic test_rst_mid();
        int bad_rdy;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            ifc.start      = 1'b1;
            ifc.a          = 32'd77777;
            ifc.b          = 32'd13;
            ifc.signed_div = 1'b0;
            rst            = (c == 22);
            #1;
        end
        total_cnt++;
        if (ifc.div_running !== 1'b0) $display("FAIL rst_mid_running: got %b expected 0", ifc.div_running);
        else pass_cnt++;
        @(negedge clk);
        rst       = 1'b0;
        ifc.start = 1'b0;
        #1;
        total_cnt++;
        if (ifc.result_ready !== 1'b0 || ifc.quotient !== 32'd0 || ifc.remainder !== 32'd0 || ifc.div_running !== 1'b0)
            $display("FAIL rst_mid_state: got ready=%b q=%h r=%h running=%b expected 0/0/0/0",
                     ifc.result_ready, ifc.quotient, ifc.remainder, ifc.div_running);
        else pass_cnt++;
        bad_rdy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (ifc.result_ready) bad_rdy++;
        end
        total_cnt++;
        if (bad_rdy !== 0) $display("FAIL rst_mid_no_result: got %0d ready cycles expected 0", bad_rdy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r, eq, er;
        logic        rid;
        int          rc, rdy, bad_run;
        ref_div(32'hFFFF0000, 32'd12345, 1'b1, eq, er);
        do_op(32'hFFFF0000, 32'd12345, 1'b1, rc, rdy, q, r, rid);
        total_cnt++;
        if (q !== eq || r !== er || rid !== 1'b0)
            $display("FAIL b2b_first: got q=%h r=%h done_running=%b expected q=%h r=%h done_running=0",
                     q, r, rid, eq, er);
        else pass_cnt++;
        ref_div(32'd4000000000, 32'd3, 1'b0, eq, er);
        do_op(32'd4000000000, 32'd3, 1'b0, rc, rdy, q, r, rid);
        total_cnt++;
        if (q !== eq || r !== er || rdy !== 34 || rc !== 33)
            $display("FAIL b2b_second: got q=%h r=%h cyc=%0d run=%0d expected q=%h r=%h cyc=34 run=33",
                     q, r, rdy, rc, eq, er);
        else pass_cnt++;
        bad_run = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            #1;
            if (ifc.div_running || ifc.result_ready) bad_run++;
        end
        total_cnt++;
        if (bad_run !== 0) $display("FAIL b2b_quiet: got %0d active cycles expected 0", bad_run);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst            = 1'b1;
        ifc.start      = 1'b0;
        ifc.signed_div = 1'b0;
        ifc.a          = 32'd0;
        ifc.b          = 32'd0;
        ifc.annul      = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
